// File: rtl/prefetch_pkg.sv
// Shared types for the prefetch refill path: flow id type and the read-request payload.
package prefetch_pkg;

    function automatic int unsigned idx_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Flow id storage is sized for the largest supported flow count; tops truncate to IDX_WIDTH.
    localparam int unsigned MAX_FLOWS     = 255;
    localparam int unsigned FLOW_ID_WIDTH = idx_width(MAX_FLOWS);

    typedef logic [FLOW_ID_WIDTH-1:0] flow_id_t;

    typedef struct packed {
        logic     valid;
        flow_id_t flow_id;
    } rd_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping at N.
module rr_arbiter
    import prefetch_pkg::*;
#(
    parameter int unsigned N  = 16,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    always_comb begin
        int unsigned j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/prefetch_refill_ctrl.sv
// Refill side of the per-flow prefetch buffer: backlog and credit tracking per flow,
// round-robin read requests to the backing store, and response-to-push forwarding.
module prefetch_refill_ctrl
    import prefetch_pkg::*;
#(
    parameter int unsigned NUM_FLOWS     = 16,
    parameter int unsigned DEPTH         = 1,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned BACKLOG_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i__enq_valid,
    input  logic [idx_width(NUM_FLOWS)-1:0] i__enq_flow_id,
    output logic                          o__enq_ready,
    output logic                          o__rd_req_valid,
    output logic [idx_width(NUM_FLOWS)-1:0] o__rd_req_flow_id,
    input  logic                          i__rd_req_ready,
    input  logic                          i__rd_rsp_valid,
    input  logic [idx_width(NUM_FLOWS)-1:0] i__rd_rsp_flow_id,
    input  logic [DATA_WIDTH-1:0]         i__rd_rsp_data,
    output logic                          o__push_valid,
    output logic [idx_width(NUM_FLOWS)-1:0] o__push_flow_id,
    output logic [DATA_WIDTH-1:0]         o__push_data,
    input  logic                          i__pop,
    input  logic [idx_width(NUM_FLOWS)-1:0] i__pop_flow_id,
    input  logic                          i__reinsert_valid,
    output logic                          o__idle
);

    localparam int unsigned IDX_WIDTH  = idx_width(NUM_FLOWS);
    localparam int unsigned CRED_WIDTH = $clog2(DEPTH + 1);

    logic [NUM_FLOWS-1:0] enq_sel;
    logic [NUM_FLOWS-1:0] pop_sel;
    logic [NUM_FLOWS-1:0] eligible;
    logic [NUM_FLOWS-1:0] bl_full;
    logic [NUM_FLOWS-1:0] bl_nz_d;
    logic [NUM_FLOWS-1:0] grant;
    logic [IDX_WIDTH-1:0] grant_idx;
    logic                 grant_any;

    rd_req_t              req_q, req_d;
    logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                 load_c;
    logic                 rsp_ok_c;
    logic                 idle_d;
    logic                 push_valid_q;
    logic [IDX_WIDTH-1:0] push_flow_id_q;
    logic [DATA_WIDTH-1:0] push_data_q;
    logic                 idle_q;

    // Out-of-range ids never match any flow, so they fall through with no effect.
    assign o__enq_ready = |(enq_sel & ~bl_full);
    assign load_c       = !req_q.valid || i__rd_req_ready;
    assign rsp_ok_c     = i__rd_rsp_valid && (i__rd_rsp_flow_id < IDX_WIDTH'(NUM_FLOWS));

    rr_arbiter #(
        .N  (NUM_FLOWS),
        .IW (IDX_WIDTH)
    ) u_rr_arbiter (
        .req       (eligible),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    for (genvar f = 0; f < NUM_FLOWS; f++) begin : g_flow
        logic [CRED_WIDTH-1:0]    credit_q, credit_d;
        logic [BACKLOG_WIDTH-1:0] backlog_q, backlog_d;
        logic                     enq_acc;
        logic                     take;
        logic                     pop_f;
        logic                     reins_f;
        int                       cred_sum;

        assign enq_sel[f]  = (i__enq_flow_id == IDX_WIDTH'(f));
        assign pop_sel[f]  = (i__pop_flow_id == IDX_WIDTH'(f));
        assign enq_acc     = i__enq_valid && enq_sel[f] && !bl_full[f];
        assign take        = load_c && grant[f];
        assign pop_f       = i__pop && pop_sel[f];
        assign reins_f     = i__reinsert_valid && pop_sel[f];
        assign eligible[f] = (credit_q != '0) && (backlog_q != '0);
        assign bl_full[f]  = &backlog_q;
        assign bl_nz_d[f]  = (backlog_d != '0);

        // Pop, reinsert and request load all land on the credit in the same cycle.
        always_comb begin
            cred_sum  = int'(credit_q) + int'(pop_f) - int'(reins_f) - int'(take);
            credit_d  = CRED_WIDTH'(cred_sum);
            backlog_d = backlog_q;
            if (enq_acc && !take) begin
                backlog_d = backlog_q + BACKLOG_WIDTH'(1);
            end else if (!enq_acc && take) begin
                backlog_d = backlog_q - BACKLOG_WIDTH'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                credit_q  <= CRED_WIDTH'(DEPTH);
                backlog_q <= '0;
            end else begin
                assert (cred_sum >= 0 && cred_sum <= int'(DEPTH));
                credit_q  <= credit_d;
                backlog_q <= backlog_d;
            end
        end
    end

    // Request register next state: reload when empty or accepted, else hold.
    always_comb begin
        req_d    = req_q;
        rr_ptr_d = rr_ptr_q;
        if (load_c) begin
            req_d.valid = grant_any;
            if (grant_any) begin
                req_d.flow_id = FLOW_ID_WIDTH'(grant_idx);
                rr_ptr_d      = (grant_idx == IDX_WIDTH'(NUM_FLOWS - 1)) ? '0
                                                                         : grant_idx + IDX_WIDTH'(1);
            end
        end
        idle_d = !(|bl_nz_d) && !req_d.valid && !rsp_ok_c;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            req_q          <= '0;
            rr_ptr_q       <= '0;
            push_valid_q   <= 1'b0;
            push_flow_id_q <= '0;
            push_data_q    <= '0;
            idle_q         <= 1'b1;
        end else begin
            req_q        <= req_d;
            rr_ptr_q     <= rr_ptr_d;
            push_valid_q <= rsp_ok_c;
            if (rsp_ok_c) begin
                push_flow_id_q <= i__rd_rsp_flow_id;
                push_data_q    <= i__rd_rsp_data;
            end
            idle_q <= idle_d;
        end
    end

    assign o__rd_req_valid   = req_q.valid;
    assign o__rd_req_flow_id = IDX_WIDTH'(req_q.flow_id);
    assign o__push_valid     = push_valid_q;
    assign o__push_flow_id   = push_flow_id_q;
    assign o__push_data      = push_data_q;
    assign o__idle           = idle_q;

endmodule

// File: tb/tb_prefetch_refill_ctrl.sv
// Directed bench for prefetch_refill_ctrl with a 2-bit backlog so saturation is reachable.
module tb_prefetch_refill_ctrl;

    localparam int unsigned IW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          i__enq_valid;
    logic [IW-1:0] i__enq_flow_id;
    logic          o__enq_ready;
    logic          o__rd_req_valid;
    logic [IW-1:0] o__rd_req_flow_id;
    logic          i__rd_req_ready;
    logic          i__rd_rsp_valid;
    logic [IW-1:0] i__rd_rsp_flow_id;
    logic [7:0]    i__rd_rsp_data;
    logic          o__push_valid;
    logic [IW-1:0] o__push_flow_id;
    logic [7:0]    o__push_data;
    logic          i__pop;
    logic [IW-1:0] i__pop_flow_id;
    logic          i__reinsert_valid;
    logic          o__idle;

    int checks = 0;
    int errors = 0;

    prefetch_refill_ctrl #(
        .NUM_FLOWS     (16),
        .DEPTH         (1),
        .DATA_WIDTH    (8),
        .BACKLOG_WIDTH (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .i__enq_valid      (i__enq_valid),
        .i__enq_flow_id    (i__enq_flow_id),
        .o__enq_ready      (o__enq_ready),
        .o__rd_req_valid   (o__rd_req_valid),
        .o__rd_req_flow_id (o__rd_req_flow_id),
        .i__rd_req_ready   (i__rd_req_ready),
        .i__rd_rsp_valid   (i__rd_rsp_valid),
        .i__rd_rsp_flow_id (i__rd_rsp_flow_id),
        .i__rd_rsp_data    (i__rd_rsp_data),
        .o__push_valid     (o__push_valid),
        .o__push_flow_id   (o__push_flow_id),
        .o__push_data      (o__push_data),
        .i__pop            (i__pop),
        .i__pop_flow_id    (i__pop_flow_id),
        .i__reinsert_valid (i__reinsert_valid),
        .o__idle           (o__idle)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic enq(input logic v, input int id);
        i__enq_valid   = v;
        i__enq_flow_id = IW'(id);
    endtask

    task automatic pop_step(input int id);
        i__pop         = 1'b1;
        i__pop_flow_id = IW'(id);
        step();
        i__pop         = 1'b0;
    endtask

    task automatic chk_req(input string tag, input logic v, input int id);
        chk({tag, "_valid"}, 32'(o__rd_req_valid), 32'(v));
        if (v) chk({tag, "_flow"}, 32'(o__rd_req_flow_id), 32'(id));
    endtask

    initial begin
        reset = 1'b0;
        i__enq_valid = 1'b0; i__enq_flow_id = '0;
        i__rd_req_ready = 1'b1;
        i__rd_rsp_valid = 1'b0; i__rd_rsp_flow_id = '0; i__rd_rsp_data = '0;
        i__pop = 1'b0; i__pop_flow_id = '0; i__reinsert_valid = 1'b0;
        @(negedge clk);
        step(); step();
        chk("rst_req_valid", 32'(o__rd_req_valid), 0);
        chk("rst_req_flow", 32'(o__rd_req_flow_id), 0);
        chk("rst_push_valid", 32'(o__push_valid), 0);
        chk("rst_push_data", 32'(o__push_data), 0);
        chk("rst_idle", 32'(o__idle), 1);
        reset = 1'b1;

        // Out-of-range flow id is refused and ignored
        enq(1'b1, 20); #1;
        chk("bad_id_enq_ready", 32'(o__enq_ready), 0);
        step(); enq(1'b0, 0);
        chk("bad_id_idle", 32'(o__idle), 1);
        step();
        chk_req("bad_id_req", 1'b0, 0);

        // 1: two enqueues on flow 3, second request waits for a pop
        enq(1'b1, 3); #1;
        chk("t1_enq_ready", 32'(o__enq_ready), 1);
        step();
        chk_req("t1_first_edge", 1'b0, 0);
        chk("t1_idle_busy", 32'(o__idle), 0);
        step(); enq(1'b0, 0);
        chk_req("t1_req", 1'b1, 3);
        step();
        chk_req("t1_no_credit", 1'b0, 0);
        step();
        chk_req("t1_still_none", 1'b0, 0);
        pop_step(3);
        chk_req("t1_pop_edge", 1'b0, 0);
        step();
        chk_req("t1_req2", 1'b1, 3);
        chk("t1_idle_req_held", 32'(o__idle), 0);
        step();
        chk_req("t1_drained", 1'b0, 0);
        chk("t1_idle", 32'(o__idle), 1);
        pop_step(3);

        // 2: flows 0, 5, 15 served back-to-back, pointer wraps after 15
        enq(1'b1, 0); step();
        enq(1'b1, 5); step();
        chk_req("t2_req0", 1'b1, 0);
        enq(1'b1, 15); step();
        chk_req("t2_req5", 1'b1, 5);
        enq(1'b0, 0); step();
        chk_req("t2_req15", 1'b1, 15);
        step();
        chk_req("t2_done", 1'b0, 0);
        pop_step(0); pop_step(5); pop_step(15);

        // 3: backpressure holds the request stable for 5 cycles
        i__rd_req_ready = 1'b0;
        enq(1'b1, 7); step();
        enq(1'b0, 0); step();
        chk_req("t3_load", 1'b1, 7);
        enq(1'b1, 9); step(); enq(1'b0, 0);
        chk_req("t3_hold0", 1'b1, 7);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_req("t3_hold", 1'b1, 7);
        end
        chk("t3_idle", 32'(o__idle), 0);
        i__rd_req_ready = 1'b1;
        step();
        chk_req("t3_next", 1'b1, 9);
        step();
        chk_req("t3_done", 1'b0, 0);
        pop_step(7); pop_step(9);

        // 4: response forwarded as a one-cycle push
        i__rd_rsp_valid = 1'b1; i__rd_rsp_flow_id = IW'(2); i__rd_rsp_data = 8'hA5;
        step(); i__rd_rsp_valid = 1'b0;
        chk("t4_push_valid", 32'(o__push_valid), 1);
        chk("t4_push_flow", 32'(o__push_flow_id), 2);
        chk("t4_push_data", 32'(o__push_data), 32'hA5);
        chk("t4_idle_push", 32'(o__idle), 0);
        step();
        chk("t4_push_once", 32'(o__push_valid), 0);
        chk("t4_idle", 32'(o__idle), 1);
        i__rd_rsp_valid = 1'b1; i__rd_rsp_flow_id = IW'(20); i__rd_rsp_data = 8'h11;
        step(); i__rd_rsp_valid = 1'b0;
        chk("t4_bad_id_push", 32'(o__push_valid), 0);

        // 5: pop+reinsert is credit-neutral; pop alone releases the next request
        enq(1'b1, 4); step(); step(); enq(1'b0, 0);
        chk_req("t5_req", 1'b1, 4);
        step();
        chk_req("t5_starved", 1'b0, 0);
        i__pop = 1'b1; i__pop_flow_id = IW'(4); i__reinsert_valid = 1'b1;
        step(); i__pop = 1'b0; i__reinsert_valid = 1'b0;
        chk_req("t5_pr_edge", 1'b0, 0);
        step();
        chk_req("t5_pr_after", 1'b0, 0);
        pop_step(4);
        chk_req("t5_pop_edge", 1'b0, 0);
        step();
        chk_req("t5_req2", 1'b1, 4);
        step();
        chk_req("t5_done", 1'b0, 0);
        pop_step(4);

        // 6: 2-bit backlog saturates at 3; exactly 3 requests drain it
        enq(1'b1, 1); step(); enq(1'b0, 0); step();
        chk_req("t6_starve", 1'b1, 1);
        step();
        for (int k = 0; k < 3; k++) begin
            enq(1'b1, 1); #1;
            chk("t6_enq_ready", 32'(o__enq_ready), 1);
            step();
        end
        #1;
        chk("t6_enq_ready_sat", 32'(o__enq_ready), 0);
        step(); enq(1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            pop_step(1);
            chk_req("t6_pop_edge", 1'b0, 0);
            step();
            chk_req("t6_req", k < 3, 1);
            step();
        end
        chk("t6_idle", 32'(o__idle), 1);

        // Reset mid-burst clears request, push and backlog; credit returns to DEPTH
        enq(1'b1, 6); step();
        i__rd_rsp_valid = 1'b1; i__rd_rsp_flow_id = IW'(6); i__rd_rsp_data = 8'h3C;
        step();
        chk_req("t6_burst_req", 1'b1, 6);
        chk("t6_burst_push", 32'(o__push_valid), 1);
        reset = 1'b0;
        step();
        chk("t6_rst_req_valid", 32'(o__rd_req_valid), 0);
        chk("t6_rst_req_flow", 32'(o__rd_req_flow_id), 0);
        chk("t6_rst_push_valid", 32'(o__push_valid), 0);
        chk("t6_rst_push_flow", 32'(o__push_flow_id), 0);
        chk("t6_rst_push_data", 32'(o__push_data), 0);
        chk("t6_rst_idle", 32'(o__idle), 1);
        reset = 1'b1; enq(1'b0, 0); i__rd_rsp_valid = 1'b0;
        step();
        chk_req("t6_post_rst", 1'b0, 0);
        chk("t6_post_rst_idle", 32'(o__idle), 1);
        enq(1'b1, 6); step(); enq(1'b0, 0); step();
        chk_req("t6_post_rst_req", 1'b1, 6);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
